uart_dbg_loader: RTL and testbench

Debug loader sitting between the UART0 receiver/transmitter and the SoC debug memory port of the hazard3 SoC. It parses a byte-oriented command stream from the host and drives `dbg_mem_op`, `dbg_wren`, `dbg_adr`, `dbg_do` and `cpu_n_reset`. This lets firmware be written into RAM (word or byte granular) while the CPU is held in reset, then released, without a simulator forcing those nets. With readback compiled in, it also reads words back over UART TX.

---
 rtl/uart_dbg_loader_pkg.sv | 29 ++
 rtl/uart_dbg_loader_field_shift.sv | 41 ++++
 rtl/uart_dbg_loader.sv | 269 ++++++++++++++++++++++++++
 tb/tb_uart_dbg_loader.sv | 385 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_dbg_loader_pkg.sv
// Shared definitions for the UART debug loader: command bytes, parser states
// and little-endian field lengths.
package uart_dbg_loader_pkg;

  localparam logic [7:0] CMD_W = 8'h57;
  localparam logic [7:0] CMD_B = 8'h42;
  localparam logic [7:0] CMD_R = 8'h52;
  localparam logic [7:0] CMD_H = 8'h48;
  localparam logic [7:0] CMD_G = 8'h47;

  localparam logic [2:0] ADDR_LEN  = 3'd4;
  localparam logic [2:0] WDATA_LEN = 3'd4;
  localparam logic [2:0] BDATA_LEN = 3'd1;

  localparam int FIELD_W = 32;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA,
    ST_MEM,
    ST_RESP
  } state_t;

  function automatic logic [3:0] lane_mask(input logic [1:0] adr_lo);
    return 4'b0001 << adr_lo;
  endfunction

endpackage

// File: rtl/uart_dbg_loader_field_shift.sv
// Little-endian byte collector for one command field (address or data).
// last_o flags that the next shifted byte completes the field of len_i bytes.
module dbg_field_shift
  import uart_dbg_loader_pkg::*;
(
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               clear_i,
  input  logic               shift_i,
  input  logic [7:0]         byte_i,
  input  logic [2:0]         len_i,
  output logic [FIELD_W-1:0] data_o,
  output logic [FIELD_W-1:0] data_nxt_o,
  output logic               last_o
);

  logic [FIELD_W-1:0] data_q, data_d;
  logic [2:0]         cnt_q;

  // Next value assumes a shift, so the parent can use the completed field in
  // the same cycle the final byte arrives.
  always_comb begin
    data_d = data_q;
    data_d[{cnt_q[1:0], 3'b000} +: 8] = byte_i;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i || clear_i) begin
      data_q <= '0;
      cnt_q  <= '0;
    end else if (shift_i) begin
      data_q <= data_d;
      cnt_q  <= cnt_q + 3'd1;
    end
  end

  assign data_o     = data_q;
  assign data_nxt_o = data_d;
  assign last_o     = (cnt_q == len_i - 3'd1);

endmodule

// File: rtl/uart_dbg_loader.sv
// UART command parser driving the SoC debug memory port and CPU reset.
// Optional word readback over UART TX is built when DBG_READBACK_EN is defined.
//
// state   | meaning
// IDLE    | wait for a command byte (H/G act here directly)
// ADDR    | collect 4 address bytes, inter-byte timeout armed
// DATA    | collect 4 (W) or 1 (B) data bytes, inter-byte timeout armed
// MEM     | dbg_mem_op held for HOLD_CYCLES cycles
// RESP    | send 4 read-data bytes, LSB first
module uart_dbg_loader
  import uart_dbg_loader_pkg::*;
#(
  parameter int HOLD_CYCLES    = 16,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        dbg_mem_op,
  output logic [3:0]  dbg_wren,
  output logic [31:0] dbg_adr,
  output logic [31:0] dbg_do,
  input  logic [31:0] dbg_di,
  output logic        cpu_n_reset
);

  localparam int HW = $clog2(HOLD_CYCLES);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_CYCLES - 1);
  localparam logic [TW-1:0] TO_LOAD   = TW'(TIMEOUT_CYCLES);

  state_t        state_q, state_d, cur_state;
  logic [7:0]    cmd_q, cmd_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [TW-1:0] to_q, to_d;
  logic          mem_op_q, mem_op_d;
  logic [3:0]    wren_q, wren_d;
  logic [31:0]   adr_q, adr_d;
  logic [31:0]   do_q, do_d;
  logic          cpu_q, cpu_d;
  logic          timeout;

  logic          field_clr, addr_shift, data_shift;
  logic [31:0]   addr_val, addr_nxt, data_val, data_nxt;
  logic          addr_last, data_last;
  logic [2:0]    data_len;

  assign data_len = (cmd_q == CMD_B) ? BDATA_LEN : WDATA_LEN;

  dbg_field_shift u_addr (
    .clk_i      (clk),
    .reset_i    (reset),
    .clear_i    (field_clr),
    .shift_i    (addr_shift),
    .byte_i     (rx_data),
    .len_i      (ADDR_LEN),
    .data_o     (addr_val),
    .data_nxt_o (addr_nxt),
    .last_o     (addr_last)
  );

  dbg_field_shift u_data (
    .clk_i      (clk),
    .reset_i    (reset),
    .clear_i    (field_clr),
    .shift_i    (data_shift),
    .byte_i     (rx_data),
    .len_i      (data_len),
    .data_o     (data_val),
    .data_nxt_o (data_nxt),
    .last_o     (data_last)
  );

`ifdef DBG_READBACK_EN
  logic [31:0] rd_q, rd_d;
  logic        tx_valid_q, tx_valid_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic [1:0]  tx_idx_q, tx_idx_d;
`endif

  // A timeout is resolved before the byte of the same cycle, which is then
  // parsed as if the FSM were already idle.
  assign timeout   = ((state_q == ST_ADDR) || (state_q == ST_DATA)) && (to_q == '0);
  assign cur_state = timeout ? ST_IDLE : state_q;

  always_comb begin
    state_d    = state_q;
    cmd_d      = cmd_q;
    hold_d     = hold_q;
    to_d       = to_q;
    mem_op_d   = mem_op_q;
    wren_d     = wren_q;
    adr_d      = adr_q;
    do_d       = do_q;
    cpu_d      = cpu_q;
    field_clr  = 1'b0;
    addr_shift = 1'b0;
    data_shift = 1'b0;
`ifdef DBG_READBACK_EN
    rd_d       = rd_q;
    tx_valid_d = tx_valid_q;
    tx_data_d  = tx_data_q;
    tx_idx_d   = tx_idx_q;
`endif
    if (timeout) state_d = ST_IDLE;
    if (to_q != '0) to_d = to_q - 1'b1;

    case (cur_state)
      ST_IDLE: begin
        if (rx_valid) begin
          case (rx_data)
            CMD_W, CMD_B: begin
              cmd_d     = rx_data;
              field_clr = 1'b1;
              to_d      = TO_LOAD;
              state_d   = ST_ADDR;
            end
`ifdef DBG_READBACK_EN
            CMD_R: begin
              cmd_d     = rx_data;
              field_clr = 1'b1;
              to_d      = TO_LOAD;
              state_d   = ST_ADDR;
            end
`endif
            CMD_H:   cpu_d = 1'b0;
            CMD_G:   cpu_d = 1'b1;
            default: ;
          endcase
        end
      end

      ST_ADDR: begin
        if (rx_valid) begin
          addr_shift = 1'b1;
          to_d       = TO_LOAD;
          if (addr_last) begin
            if (cmd_q == CMD_R) begin
              state_d  = ST_MEM;
              mem_op_d = 1'b1;
              hold_d   = HOLD_LOAD;
              adr_d    = addr_nxt;
              wren_d   = 4'h0;
            end else begin
              state_d = ST_DATA;
            end
          end
        end
      end

      ST_DATA: begin
        if (rx_valid) begin
          data_shift = 1'b1;
          to_d       = TO_LOAD;
          if (data_last) begin
            state_d  = ST_MEM;
            mem_op_d = 1'b1;
            hold_d   = HOLD_LOAD;
            adr_d    = addr_val;
            if (cmd_q == CMD_B) begin
              do_d   = {4{rx_data}};
              wren_d = lane_mask(addr_val[1:0]);
            end else begin
              do_d   = data_nxt;
              wren_d = 4'hF;
            end
          end
        end
      end

      ST_MEM: begin
        if (hold_q == '0) begin
          mem_op_d = 1'b0;
          wren_d   = 4'h0;
          state_d  = ST_IDLE;
`ifdef DBG_READBACK_EN
          if (cmd_q == CMD_R) begin
            rd_d       = dbg_di;
            tx_valid_d = 1'b1;
            tx_data_d  = dbg_di[7:0];
            tx_idx_d   = 2'd0;
            state_d    = ST_RESP;
          end
`endif
        end else begin
          hold_d = hold_q - 1'b1;
        end
      end

`ifdef DBG_READBACK_EN
      ST_RESP: begin
        // One idle cycle after every handshake before the next byte.
        if (tx_valid_q) begin
          if (tx_ready) begin
            tx_valid_d = 1'b0;
            if (tx_idx_q == 2'd3) state_d = ST_IDLE;
            else tx_idx_d = tx_idx_q + 2'd1;
          end
        end else begin
          tx_valid_d = 1'b1;
          tx_data_d  = rd_q[{tx_idx_q, 3'b000} +: 8];
        end
      end
`endif

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cmd_q    <= '0;
      hold_q   <= '0;
      to_q     <= '0;
      mem_op_q <= 1'b0;
      wren_q   <= '0;
      adr_q    <= '0;
      do_q     <= '0;
      cpu_q    <= 1'b1;
    end else begin
      state_q  <= state_d;
      cmd_q    <= cmd_d;
      hold_q   <= hold_d;
      to_q     <= to_d;
      mem_op_q <= mem_op_d;
      wren_q   <= wren_d;
      adr_q    <= adr_d;
      do_q     <= do_d;
      cpu_q    <= cpu_d;
    end
  end

`ifdef DBG_READBACK_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_q       <= '0;
      tx_valid_q <= 1'b0;
      tx_data_q  <= '0;
      tx_idx_q   <= '0;
    end else begin
      rd_q       <= rd_d;
      tx_valid_q <= tx_valid_d;
      tx_data_q  <= tx_data_d;
      tx_idx_q   <= tx_idx_d;
    end
  end

  assign tx_valid = tx_valid_q;
  assign tx_data  = tx_data_q;
`else
  assign tx_valid = 1'b0;
  assign tx_data  = 8'h00;
`endif

  logic unused_sig;
  assign unused_sig = ^{data_val, tx_ready, dbg_di};

  assign dbg_mem_op  = mem_op_q;
  assign dbg_wren    = wren_q;
  assign dbg_adr     = adr_q;
  assign dbg_do      = do_q;
  assign cpu_n_reset = cpu_q;

endmodule

// File: tb/tb_uart_dbg_loader.sv
// Self-checking bench for uart_dbg_loader: directed vector table, hand-written
// corner sequences and randomized commands against a command-level model.
module tb_uart_dbg_loader;

  localparam int HOLD = 5;
  localparam int TMO  = 40;
  localparam logic [31:0] DI_KEY = 32'hA5C3_5A3C;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        dbg_mem_op;
  logic [3:0]  dbg_wren;
  logic [31:0] dbg_adr, dbg_do, dbg_di;
  logic        cpu_n_reset;

  logic        di_force;
  logic [31:0] di_val;
  assign dbg_di = di_force ? di_val : (dbg_adr ^ DI_KEY);

  uart_dbg_loader #(.HOLD_CYCLES(HOLD), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset(reset),
    .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .dbg_mem_op(dbg_mem_op), .dbg_wren(dbg_wren), .dbg_adr(dbg_adr),
    .dbg_do(dbg_do), .dbg_di(dbg_di), .cpu_n_reset(cpu_n_reset)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, cyc=%0d required<50000", cyc);
    $fatal(1);
  end

  // ---------------- observation of the memory port and TX ----------------
  typedef struct {
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  wren;
    int          len;
    int          start;
    bit          stable;
  } acc_t;

  acc_t       acc_q[$];
  acc_t       cur;
  bit         in_acc = 0;
  int         idle_wren_bad = 0;
  logic [7:0] tx_q[$];
  int         tx_cyc_q[$];

  always @(negedge clk) begin
    if (dbg_mem_op === 1'b1) begin
      if (!in_acc) begin
        in_acc     = 1;
        cur.adr    = dbg_adr;
        cur.dat    = dbg_do;
        cur.wren   = dbg_wren;
        cur.len    = 0;
        cur.start  = cyc;
        cur.stable = 1;
      end else if (dbg_adr !== cur.adr || dbg_do !== cur.dat || dbg_wren !== cur.wren) begin
        cur.stable = 0;
      end
      cur.len++;
    end else begin
      if (in_acc) begin
        in_acc = 0;
        acc_q.push_back(cur);
      end
      if (reset !== 1'b1 && dbg_wren !== 4'h0) idle_wren_bad++;
    end
    if (tx_valid === 1'b1 && tx_ready === 1'b1) begin
      tx_q.push_back(tx_data);
      tx_cyc_q.push_back(cyc);
    end
  end

  // ---------------- check helpers ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int last_drive = 0;

  task automatic send_byte(input logic [7:0] b);
    rx_data    = b;
    rx_valid   = 1'b1;
    last_drive = cyc;
    tick();
    rx_valid   = 1'b0;
  endtask

  task automatic send_cmd(input logic [7:0] c, input logic [31:0] a, input logic [31:0] d,
                          input int na, input int nd, input int maxgap);
    logic [31:0] aa, dd;
    aa = a;
    dd = d;
    send_byte(c);
    for (int i = 0; i < na; i++) begin
      repeat ($urandom_range(0, maxgap)) tick();
      send_byte(aa[7:0]);
      aa = aa >> 8;
    end
    for (int i = 0; i < nd; i++) begin
      repeat ($urandom_range(0, maxgap)) tick();
      send_byte(dd[7:0]);
      dd = dd >> 8;
    end
  endtask

  task automatic check_access(input string nm, input logic [31:0] ea, input logic [31:0] ed,
                              input logic [3:0] ew, input bit chk_do, input int es,
                              output int st);
    acc_t a;
    bit   ok;
    ok = 0;
    st = 0;
    for (int i = 0; i < 100 && !ok; i++) begin
      if (acc_q.size() > 0) begin
        a  = acc_q.pop_front();
        ok = 1;
      end else begin
        tick();
      end
    end
    chk({nm, "_seen"}, 32'(ok), 32'd1);
    if (ok) begin
      st = a.start;
      chk({nm, "_adr"}, a.adr, ea);
      if (chk_do) chk({nm, "_do"}, a.dat, ed);
      chk({nm, "_wren"}, 32'(a.wren), 32'(ew));
      chk({nm, "_len"}, a.len, HOLD);
      chk({nm, "_stable"}, 32'(a.stable), 32'd1);
      if (es >= 0) chk({nm, "_start"}, a.start, es);
    end
  endtask

  task automatic collect_tx(input int n, input bit rnd_ready);
    for (int i = 0; i < 300 && tx_q.size() < n; i++) begin
      if (rnd_ready) tx_ready = 1'($urandom_range(0, 1));
      tick();
    end
    tx_ready = 1'b0;
    chk("tx_count", tx_q.size(), n);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [7:0]  cmd;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [31:0] exp_do;
    logic [3:0]  exp_wren;
  } vec_t;

  vec_t vecs[6];

  logic        exp_cpu;
  int          st;
  logic [31:0] w;

  initial begin
    vecs[0] = '{8'h57, 32'h0002_0000, 32'h0320_0593, 32'h0320_0593, 4'hF};
    vecs[1] = '{8'h42, 32'h0000_000C, 32'h0000_0032, 32'h3232_3232, 4'h1};
    vecs[2] = '{8'h42, 32'h0000_000D, 32'h0000_0031, 32'h3131_3131, 4'h2};
    vecs[3] = '{8'h42, 32'h8000_000F, 32'h0000_00A7, 32'hA7A7_A7A7, 4'h8};
    vecs[4] = '{8'h42, 32'h1234_5676, 32'h0000_005C, 32'h5C5C_5C5C, 4'h4};
    vecs[5] = '{8'h57, 32'h0000_1003, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 4'hF};

    reset    = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    tx_ready = 1'b0;
    di_force = 1'b0;
    di_val   = 32'h0;
    repeat (3) tick();
    chk("rst_mem_op", 32'(dbg_mem_op), 32'd0);
    chk("rst_wren", 32'(dbg_wren), 32'd0);
    chk("rst_adr", dbg_adr, 32'd0);
    chk("rst_do", dbg_do, 32'd0);
    chk("rst_cpu", 32'(cpu_n_reset), 32'd1);
    chk("rst_tx_valid", 32'(tx_valid), 32'd0);
    chk("rst_tx_data", 32'(tx_data), 32'd0);
    reset = 1'b0;
    tick();

    // H then the vector table
    send_byte(8'h48);
    chk("h_cpu", 32'(cpu_n_reset), 32'd0);
    for (int i = 0; i < 6; i++) begin
      send_cmd(vecs[i].cmd, vecs[i].adr, vecs[i].dat, 4, (vecs[i].cmd == 8'h57) ? 4 : 1, 0);
      check_access($sformatf("vec%0d", i), vecs[i].adr, vecs[i].exp_do, vecs[i].exp_wren,
                   1, last_drive + 1, st);
    end
    chk("vec_cpu_held", 32'(cpu_n_reset), 32'd0);
    send_byte(8'h47);
    chk("g_cpu", 32'(cpu_n_reset), 32'd1);

`ifdef DBG_READBACK_EN
    // readback with a stalled transmitter
    di_force = 1'b1;
    di_val   = 32'h0000_3132;
    send_cmd(8'h52, 32'h0000_000C, 32'h0, 4, 0, 0);
    check_access("rd_stall", 32'h0000_000C, 32'h0, 4'h0, 0, last_drive + 1, st);
    begin
      int good;
      good = 0;
      for (int i = 0; i < 10; i++) begin
        if (tx_valid === 1'b1 && tx_data === 8'h32) good++;
        tick();
      end
      chk("rd_stall_hold", good, 10);
    end
    tx_ready = 1'b1;
    collect_tx(4, 0);
    w = 32'h0000_3132;
    for (int i = 0; i < 4 && tx_q.size() > 0; i++) chk($sformatf("rd_stall_b%0d", i), 32'(tx_q.pop_front()), 32'(w[8*i +: 8]));
    tx_cyc_q.delete();
    di_force = 1'b0;

    // readback with tx_ready high: first byte the cycle after MEM, then 1 per 2 cycles
    tx_ready = 1'b1;
    send_cmd(8'h52, 32'h0000_0040, 32'h0, 4, 0, 0);
    check_access("rd_fast", 32'h0000_0040, 32'h0, 4'h0, 0, last_drive + 1, st);
    collect_tx(4, 0);
    w = 32'h0000_0040 ^ DI_KEY;
    if (tx_cyc_q.size() == 4) begin
      chk("rd_fast_first", tx_cyc_q[0], st + HOLD);
      for (int i = 1; i < 4; i++) chk($sformatf("rd_fast_gap%0d", i), tx_cyc_q[i] - tx_cyc_q[i-1], 2);
    end
    for (int i = 0; i < 4 && tx_q.size() > 0; i++) chk($sformatf("rd_fast_b%0d", i), 32'(tx_q.pop_front()), 32'(w[8*i +: 8]));
    tx_cyc_q.delete();
    tick();
    chk("rd_fast_done", 32'(tx_valid), 32'd0);
`else
    // without readback, R and its address bytes are ignored
    tx_ready = 1'b1;
    send_cmd(8'h52, 32'h0000_000C, 32'h0, 4, 0, 0);
    repeat (HOLD + 10) tick();
    chk("r_ignored_acc", acc_q.size(), 0);
    chk("r_ignored_tx", tx_q.size(), 0);
    chk("r_ignored_txv", 32'(tx_valid), 32'd0);
    tx_ready = 1'b0;
`endif

    // timeout after 3 address bytes, then a normal W
    send_cmd(8'h57, 32'h0000_0100, 32'h0, 3, 0, 0);
    repeat (TMO + 5) tick();
    chk("tmo_no_access", acc_q.size(), 0);
    send_cmd(8'h57, 32'h0000_0200, 32'h1122_3344, 4, 4, 0);
    check_access("tmo_next_w", 32'h0000_0200, 32'h1122_3344, 4'hF, 1, last_drive + 1, st);

    // TMO-1 idle cycles: last address byte still accepted
    send_cmd(8'h57, 32'h0000_0300, 32'h0, 3, 0, 0);
    repeat (TMO - 1) tick();
    send_byte(8'h00);
    send_cmd(8'h55, 32'h0, 32'h0, 0, 0, 0);
    send_byte(8'h66);
    send_byte(8'h77);
    send_byte(8'h88);
    // data bytes sent: 0x55,0x66,0x77,0x88
    check_access("tmo_edge_ok", 32'h0000_0300, 32'h8877_6655, 4'hF, 1, last_drive + 1, st);

    // exactly TMO idle cycles: the timeout wins, byte is parsed as H
    send_cmd(8'h57, 32'h0000_0400, 32'h0, 3, 0, 0);
    repeat (TMO) tick();
    send_byte(8'h48);
    chk("tmo_win_cpu", 32'(cpu_n_reset), 32'd0);
    repeat (TMO + 5) tick();
    chk("tmo_win_no_acc", acc_q.size(), 0);
    send_byte(8'h47);
    chk("tmo_win_g", 32'(cpu_n_reset), 32'd1);

    // reset during MEM of a W with the CPU held
    send_byte(8'h48);
    send_cmd(8'h57, 32'h0000_0500, 32'hCAFE_F00D, 4, 4, 0);
    begin
      bit seen;
      seen = 0;
      for (int i = 0; i < 20 && !seen; i++) begin
        if (dbg_mem_op === 1'b1) seen = 1;
        else tick();
      end
      chk("rstmem_seen", 32'(seen), 32'd1);
    end
    tick();
    reset = 1'b1;
    tick();
    chk("rstmem_mem_op", 32'(dbg_mem_op), 32'd0);
    chk("rstmem_cpu", 32'(cpu_n_reset), 32'd1);
    chk("rstmem_wren", 32'(dbg_wren), 32'd0);
    reset = 1'b0;
    tick();
    acc_q.delete();
    send_byte(8'h00);
    send_byte(8'h47);
    tick();
    chk("rstmem_g_cpu", 32'(cpu_n_reset), 32'd1);
    chk("rstmem_no_acc", acc_q.size(), 0);
    send_cmd(8'h57, 32'h0000_0600, 32'h0BAD_F00D, 4, 4, 0);
    check_access("rstmem_next_w", 32'h0000_0600, 32'h0BAD_F00D, 4'hF, 1, last_drive + 1, st);

    // randomized commands against the command-level model
    exp_cpu = 1'b1;
    for (int it = 0; it < 30; it++) begin
      int          kind;
      logic [31:0] a, d;
      logic [7:0]  b;
      kind = $urandom_range(0, 5);
      a    = $urandom;
      d    = $urandom;
      case (kind)
        0: begin
          send_cmd(8'h57, a, d, 4, 4, 3);
          check_access("rnd_w", a, d, 4'hF, 1, last_drive + 1, st);
        end
        1: begin
          send_cmd(8'h42, a, d, 4, 1, 3);
          b = d[7:0];
          check_access("rnd_b", a, {b, b, b, b}, 4'(1 << a[1:0]), 1, last_drive + 1, st);
        end
        2: begin
          send_byte(8'h48);
          exp_cpu = 1'b0;
          chk("rnd_h", 32'(cpu_n_reset), 32'(exp_cpu));
        end
        3: begin
          send_byte(8'h47);
          exp_cpu = 1'b1;
          chk("rnd_g", 32'(cpu_n_reset), 32'(exp_cpu));
        end
`ifdef DBG_READBACK_EN
        5: begin
          send_cmd(8'h52, a, 32'h0, 4, 0, 3);
          check_access("rnd_r", a, 32'h0, 4'h0, 0, last_drive + 1, st);
          collect_tx(4, 1);
          w = a ^ DI_KEY;
          for (int i = 0; i < 4 && tx_q.size() > 0; i++) chk("rnd_r_byte", 32'(tx_q.pop_front()), 32'(w[8*i +: 8]));
          tx_cyc_q.delete();
        end
`endif
        default: begin
          do b = 8'($urandom_range(0, 255));
          while (b == 8'h57 || b == 8'h42 || b == 8'h48 || b == 8'h47
`ifdef DBG_READBACK_EN
                 || b == 8'h52
`endif
                 );
          send_byte(b);
          repeat (HOLD + 3) tick();
          chk("rnd_junk_no_acc", acc_q.size(), 0);
          chk("rnd_junk_cpu", 32'(cpu_n_reset), 32'(exp_cpu));
        end
      endcase
    end

    repeat (5) tick();
    chk("wren_zero_when_idle", idle_wren_bad, 0);
    chk("no_stray_access", acc_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
